fd_reg: RTL and testbench
=========================

# fd_reg

F/D pipeline register of the five-stage MIPS core with precise exceptions. It captures the fetched PC and instruction every enabled cycle and checks the fetch address for AdEL. It also marks branch-delay-slot instructions and inserts nop bubbles on exception entry or flush. It sits between the PC/instruction-memory fetch logic and the D-stage decoder/hazard unit.

## Interface
Parameters:
- PC_RESET, 32'h00003000, value of Pc_D after reset.
- PC_HANDLER, 32'h00004180, value of Pc_D after req.
- IM_LO, 32'h00003000, lowest legal fetch address.
- IM_HI, 32'h00006ffc, highest legal fetch address.
- EXC_ADEL, 5'd4, ExcCode for fetch address error.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  exception/interrupt taken this cycle; flushes the register.
- flush  in  1  D-stage clear (eret in D); inserts a bubble.
- En_FD  in  1  1 = capture F-stage values; 0 = hold (stall).
- Pc_F  in  32  PC of instruction in F.
- Instr_F  in  32  instruction word read at Pc_F.
- Jump_D  in  1  instruction currently in D is a branch/jump (decoder output).
- Pc_D  out  32  PC of instruction in D.
- Instr_D  out  32  instruction in D (32'h0 for bubbles and faulting fetches).
- BD_D  out  1  instruction in D is in a delay slot.
- ExcCode_D  out  5  fetch exception code (0 = none).
- Valid_D  out  1  D holds a real instruction, not a bubble.

## Operation
- Fetch check, combinational on Pc_F: AdEL when Pc_F[1:0] != 0, Pc_F < IM_LO, or Pc_F > IM_HI. Compare unsigned, full 32 bits.
- Update priority, evaluated at the rising edge of clk:
  - reset low: Pc_D=PC_RESET, Instr_D=0, BD_D=0, ExcCode_D=0, Valid_D=0.
  - else req=1: Pc_D=PC_HANDLER, Instr_D=0, BD_D=0, ExcCode_D=0, Valid_D=0. req overrides flush and En_FD=0.
  - else flush=1: Pc_D=Pc_F, Instr_D=0, BD_D=0, ExcCode_D=0, Valid_D=0. Overrides stall.
  - else En_FD=0: every output holds, including BD_D and ExcCode_D.
  - else capture with AdEL: Pc_D=Pc_F, Instr_D=0, ExcCode_D=EXC_ADEL, BD_D=Jump_D, Valid_D=1.
  - else capture without AdEL: Pc_D=Pc_F, Instr_D=Instr_F, ExcCode_D=0, BD_D=Jump_D, Valid_D=1.
- BD_D is sampled from Jump_D of the instruction leaving D in the same edge. A stalled branch therefore does not set BD on anything until the slot instruction is actually captured.
- Bubbles carry a meaningful Pc_D. Downstream EPC logic uses it (bubble Pc_D = PC_HANDLER or Pc_F).
- A faulting fetch still advances as a valid instruction so the exception is reported precisely in M. Its word is forced to nop so decode has no side effects.

## Timing
- Latency: 1 cycle F to D. Outputs are registered only; no combinational input-to-output path.
- Reset asserts asynchronously: outputs take reset values immediately on the falling edge of reset, without waiting for clk. Deassertion takes effect at the first rising edge with reset high.
- Reset mid-stall or mid-req: reset wins, with no residue of the prior state.
- req and flush in the same cycle: req result. flush and En_FD=0 in the same cycle: flush result (bubble). The PC stage is held separately by the hazard unit.
- Consecutive stalls: values persist indefinitely. Release with En_FD=1 captures the current Pc_F/Instr_F at that edge.
- Boundary addresses: Pc_F=IM_LO and IM_HI legal; IM_HI+4 (32'h00007000) and IM_LO-4 (32'h00002ffc) raise AdEL; 32'hfffffffc raises AdEL with no wrap.

## Test plan
- Reset: drive reset=0 between clock edges -> outputs become 0x3000/0/0/0/0 before the next edge. Release, capture Pc_F=0x3000, Instr_F=0x24010001 -> Pc_D=0x3000, Instr_D=0x24010001, Valid_D=1.
- Stall/release: capture 0x3004, hold En_FD=0 for 3 cycles with Pc_F changing -> Pc_D stays 0x3004. Raise En_FD with Pc_F=0x3008 -> Pc_D=0x3008 next edge.
- AdEL: Pc_F=0x3002 -> Instr_D=0, ExcCode_D=4, Valid_D=1. Repeat with Pc_F=0x7000 and 0x2ffc -> ExcCode_D=4. Pc_F=0x6ffc -> ExcCode_D=0.
- Delay slot: Jump_D=1 with En_FD=1, Pc_F=0x3010 -> BD_D=1. Jump_D=1 with En_FD=0 -> BD_D unchanged.
- Priority: req=1, flush=1, En_FD=0 together -> Pc_D=0x4180, Valid_D=0. Then flush=1, En_FD=0, Pc_F=0x3020 -> Pc_D=0x3020, Instr_D=0, Valid_D=0.
- Async reset during req cycle: pulse reset low mid-cycle while req=1 -> Pc_D=0x3000 immediately, not 0x4180.

Source files
------------

// File: rtl/fd_reg_if.sv
// F/D pipeline register bus: F-stage fetch values and D-stage control in,
// registered D-stage instruction state out.
interface fd_reg_if;
    logic        req;
    logic        flush;
    logic        En_FD;
    logic [31:0] Pc_F;
    logic [31:0] Instr_F;
    logic        Jump_D;
    logic [31:0] Pc_D;
    logic [31:0] Instr_D;
    logic        BD_D;
    logic [4:0]  ExcCode_D;
    logic        Valid_D;

    // Fetch/hazard side: drives the F-stage values and pipeline control.
    modport master (
        output req, flush, En_FD, Pc_F, Instr_F, Jump_D,
        input  Pc_D, Instr_D, BD_D, ExcCode_D, Valid_D
    );

    // Register side: consumes F-stage values, presents the D-stage state.
    modport slave (
        input  req, flush, En_FD, Pc_F, Instr_F, Jump_D,
        output Pc_D, Instr_D, BD_D, ExcCode_D, Valid_D
    );
endinterface

// File: rtl/fd_reg.sv
// F/D pipeline register. Captures PC/instruction from fetch, flags fetch
// address errors (AdEL), marks delay-slot instructions and inserts bubbles
// on exception entry or flush.
module fd_reg #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input logic     clk,
    input logic     reset,
    fd_reg_if.slave fd
);

    logic adel;

    // Fetch address check: misaligned or outside instruction memory (unsigned).
    always_comb begin
        adel = (fd.Pc_F[1:0] != 2'b00) || (fd.Pc_F < IM_LO) || (fd.Pc_F > IM_HI);
    end

    // D-stage state: reset > req > flush > stall > capture. Bubbles keep a
    // meaningful PC because EPC logic downstream reads it. A faulting fetch
    // still advances as valid (nop word) so the exception is reported in order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fd.Pc_D      <= PC_RESET;
            fd.Instr_D   <= 32'h0;
            fd.BD_D      <= 1'b0;
            fd.ExcCode_D <= 5'd0;
            fd.Valid_D   <= 1'b0;
        end else if (fd.req) begin
            fd.Pc_D      <= PC_HANDLER;
            fd.Instr_D   <= 32'h0;
            fd.BD_D      <= 1'b0;
            fd.ExcCode_D <= 5'd0;
            fd.Valid_D   <= 1'b0;
        end else if (fd.flush) begin
            fd.Pc_D      <= fd.Pc_F;
            fd.Instr_D   <= 32'h0;
            fd.BD_D      <= 1'b0;
            fd.ExcCode_D <= 5'd0;
            fd.Valid_D   <= 1'b0;
        end else if (fd.En_FD) begin
            // Jump_D belongs to the instruction leaving D on this edge, so a
            // stalled branch marks nothing until its slot is really captured.
            fd.Pc_D      <= fd.Pc_F;
            fd.Instr_D   <= adel ? 32'h0 : fd.Instr_F;
            fd.BD_D      <= fd.Jump_D;
            fd.ExcCode_D <= adel ? EXC_ADEL : 5'd0;
            fd.Valid_D   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fd_reg.sv
// Bench for fd_reg: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_fd_reg;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
    localparam logic [31:0] IM_LO      = 32'h0000_3000;
    localparam logic [31:0] IM_HI      = 32'h0000_6ffc;

    logic clk;
    logic reset;
    fd_reg_if bus ();

    fd_reg dut (
        .clk   (clk),
        .reset (reset),
        .fd    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what D must hold after each edge.
    logic [31:0] m_pc, m_instr;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid;

    function automatic bit fetch_ok(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc >= IM_LO) && (pc <= IM_HI);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc <= PC_RESET; m_instr <= 0; m_exc <= 0; m_bd <= 0; m_valid <= 0;
        end else if (bus.req) begin
            m_pc <= PC_HANDLER; m_instr <= 0; m_exc <= 0; m_bd <= 0; m_valid <= 0;
        end else if (bus.flush) begin
            m_pc <= bus.Pc_F; m_instr <= 0; m_exc <= 0; m_bd <= 0; m_valid <= 0;
        end else if (bus.En_FD) begin
            m_pc    <= bus.Pc_F;
            m_instr <= fetch_ok(bus.Pc_F) ? bus.Instr_F : 32'h0;
            m_exc   <= fetch_ok(bus.Pc_F) ? 5'd0 : 5'd4;
            m_bd    <= bus.Jump_D;
            m_valid <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.Pc_D",      bus.Pc_D,             m_pc);
            chk("m.Instr_D",   bus.Instr_D,          m_instr);
            chk("m.ExcCode_D", {27'b0, bus.ExcCode_D}, {27'b0, m_exc});
            chk("m.BD_D",      {31'b0, bus.BD_D},    {31'b0, m_bd});
            chk("m.Valid_D",   {31'b0, bus.Valid_D}, {31'b0, m_valid});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic en,
                         input logic [31:0] pc, input logic [31:0] ins, input logic j);
        bus.req = r; bus.flush = f; bus.En_FD = en;
        bus.Pc_F = pc; bus.Instr_F = ins; bus.Jump_D = j;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        case ($urandom_range(0, 9))
            0: pc = IM_LO;
            1: pc = IM_HI;
            2: pc = IM_HI + 32'd4;
            3: pc = IM_LO - 32'd4;
            4: pc = 32'hffff_fffc;
            5: pc = IM_LO + ($urandom_range(0, 32'h3fff) & 32'hffff_fffc) + 32'd1;
            6: pc = $urandom();
            default: pc = IM_LO + ($urandom_range(0, 32'h3fff) << 2) % 32'h4000;
        endcase
        return pc;
    endfunction

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        cyc(); cyc();
        chk("rst.Pc_D",    bus.Pc_D, 32'h3000);
        chk("rst.Instr_D", bus.Instr_D, 32'h0);
        chk("rst.Valid_D", {31'b0, bus.Valid_D}, 32'h0);
        chk("rst.BD_D",    {31'b0, bus.BD_D}, 32'h0);
        chk("rst.Exc_D",   {27'b0, bus.ExcCode_D}, 32'h0);
        reset = 1'b1;
        cmp_en = 1'b1;

        // Capture, then asynchronous reset between edges.
        drive(0, 0, 1, 32'h3100, 32'hdeadbeef, 0);
        cyc();
        chk("cap.Pc_D", bus.Pc_D, 32'h3100);
        #2 reset = 1'b0;
        #1;
        chk("arst.Pc_D",    bus.Pc_D, 32'h3000);
        chk("arst.Valid_D", {31'b0, bus.Valid_D}, 32'h0);
        reset = 1'b1;
        drive(0, 0, 1, 32'h3000, 32'h24010001, 0);
        cyc();
        chk("rel.Pc_D",    bus.Pc_D, 32'h3000);
        chk("rel.Instr_D", bus.Instr_D, 32'h24010001);
        chk("rel.Valid_D", {31'b0, bus.Valid_D}, 32'h1);

        // Stall and release.
        drive(0, 0, 1, 32'h3004, 32'h11111111, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'h3040 + 32'(i * 4), 32'h0, 0);
            cyc();
            chk("stall.Pc_D", bus.Pc_D, 32'h3004);
        end
        drive(0, 0, 1, 32'h3008, 32'h33333333, 0);
        cyc();
        chk("release.Pc_D", bus.Pc_D, 32'h3008);

        // Fetch address errors and boundaries.
        drive(0, 0, 1, 32'h3002, 32'h44444444, 0);
        cyc();
        chk("adel3002.Instr", bus.Instr_D, 32'h0);
        chk("adel3002.Exc",   {27'b0, bus.ExcCode_D}, 32'h4);
        chk("adel3002.Valid", {31'b0, bus.Valid_D}, 32'h1);
        drive(0, 0, 1, 32'h7000, 32'h44444444, 0);
        cyc();
        chk("adel7000.Exc", {27'b0, bus.ExcCode_D}, 32'h4);
        drive(0, 0, 1, 32'h2ffc, 32'h44444444, 0);
        cyc();
        chk("adel2ffc.Exc", {27'b0, bus.ExcCode_D}, 32'h4);
        drive(0, 0, 1, 32'hfffffffc, 32'h44444444, 0);
        cyc();
        chk("adelfffc.Exc", {27'b0, bus.ExcCode_D}, 32'h4);
        drive(0, 0, 1, 32'h6ffc, 32'h22222222, 0);
        cyc();
        chk("ok6ffc.Exc",   {27'b0, bus.ExcCode_D}, 32'h0);
        chk("ok6ffc.Instr", bus.Instr_D, 32'h22222222);

        // Delay slot marking.
        drive(0, 0, 1, 32'h3010, 32'h55555555, 1);
        cyc();
        chk("bd.set", {31'b0, bus.BD_D}, 32'h1);
        drive(0, 0, 1, 32'h3014, 32'h66666666, 0);
        cyc();
        chk("bd.clr", {31'b0, bus.BD_D}, 32'h0);
        drive(0, 0, 0, 32'h3018, 32'h77777777, 1);
        cyc();
        chk("bd.stall", {31'b0, bus.BD_D}, 32'h0);

        // Priority: req over flush over stall.
        drive(1, 1, 0, 32'h3050, 32'h88888888, 1);
        cyc();
        chk("req.Pc_D",    bus.Pc_D, 32'h4180);
        chk("req.Valid_D", {31'b0, bus.Valid_D}, 32'h0);
        drive(0, 1, 0, 32'h3020, 32'h99999999, 1);
        cyc();
        chk("flush.Pc_D",    bus.Pc_D, 32'h3020);
        chk("flush.Instr_D", bus.Instr_D, 32'h0);
        chk("flush.Valid_D", {31'b0, bus.Valid_D}, 32'h0);

        // Asynchronous reset during a req cycle.
        drive(1, 0, 1, 32'h3024, 32'h12345678, 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_req.now", bus.Pc_D, 32'h3000);
        cyc();
        chk("arst_req.edge", bus.Pc_D, 32'h3000);
        reset = 1'b1;

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            reset = 1'b1;
            drive(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 75), rand_pc(), $urandom(),
                  ($urandom_range(0, 99) < 30));
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                #1;
                chk("rnd_arst.Pc_D", bus.Pc_D, 32'h3000);
            end
            cyc();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
